// File: rtl/uart_receiver_if.sv
// Byte-side handshake bundle between the UART receiver and its consumer.
interface uart_receiver_if;
    logic [7:0] data_out;
    logic       data_out_valid;
    logic       data_out_ready;
    logic       framing_error;
    logic       overrun;

    modport master (
        output data_out,
        output data_out_valid,
        output framing_error,
        output overrun,
        input  data_out_ready
    );

    modport slave (
        input  data_out,
        input  data_out_valid,
        input  framing_error,
        input  overrun,
        output data_out_ready
    );
endinterface

// File: rtl/uart_receiver.sv
// 8N1 UART receiver: synchronizes serial_in, reassembles LSB-first frames and
// hands each byte to the consumer through a valid/ready handshake.
//
// state     | meaning
// ----------+------------------------------------------------------------
// S_IDLE    | line idle, waiting for a falling edge on rx
// S_START   | timing to the start-bit centre to reject glitches
// S_DATA    | sampling the eight data bits, one per bit period
// S_STOP    | sampling the stop bit, then deliver / overrun / framing error
// S_WAIT_HI | stop bit was low (break); wait for the line to return high
module uart_receiver #(
    parameter int CLOCK_FREQ = 50_000_000,
    parameter int BAUD_RATE  = 1_000_000
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            serial_in,
    uart_receiver_if.master rx_if
);

    localparam int SYMBOL_EDGE_TIME = CLOCK_FREQ / BAUD_RATE;
    localparam int SAMPLE_TIME      = SYMBOL_EDGE_TIME / 2;
    localparam int CNT_W            = $clog2(SYMBOL_EDGE_TIME);

    localparam logic [CNT_W-1:0] SAMPLE_LOAD = CNT_W'(SAMPLE_TIME - 1);
    localparam logic [CNT_W-1:0] BIT_LOAD    = CNT_W'(SYMBOL_EDGE_TIME - 1);

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_START   = 3'd1;
    localparam logic [2:0] S_DATA    = 3'd2;
    localparam logic [2:0] S_STOP    = 3'd3;
    localparam logic [2:0] S_WAIT_HI = 3'd4;

    if (SYMBOL_EDGE_TIME < 4) begin : g_param_check
        $error("uart_receiver: CLOCK_FREQ/BAUD_RATE must be at least 4");
    end

    logic             sync_q;
    logic             rx_q;
    logic [2:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       idx_q, idx_d;
    logic [7:0]       shift_q, shift_d;
    logic [7:0]       data_q, data_d;
    logic             valid_q, valid_d;
    logic             ferr_q, ferr_d;
    logic             ovr_q, ovr_d;
    logic             tc;

    // Timer counts down from (period-1); terminal count marks the sample point.
    assign tc = (cnt_q == '0);

    always_comb begin
        state_d = state_q;
        cnt_d   = tc ? cnt_q : cnt_q - CNT_W'(1);
        idx_d   = idx_q;
        shift_d = shift_q;
        data_d  = data_q;
        valid_d = valid_q && !rx_if.data_out_ready;
        ferr_d  = 1'b0;
        ovr_d   = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (!rx_q) begin
                    state_d = S_START;
                    cnt_d   = SAMPLE_LOAD;
                end
            end
            S_START: begin
                if (tc) begin
                    if (!rx_q) begin
                        state_d = S_DATA;
                        cnt_d   = BIT_LOAD;
                        idx_d   = 3'd0;
                    end else begin
                        state_d = S_IDLE;
                        cnt_d   = '0;
                    end
                end
            end
            S_DATA: begin
                if (tc) begin
                    shift_d[idx_q] = rx_q;
                    idx_d          = idx_q + 3'd1;
                    cnt_d          = BIT_LOAD;
                    if (idx_q == 3'd7) begin
                        state_d = S_STOP;
                    end
                end
            end
            S_STOP: begin
                if (tc) begin
                    cnt_d = '0;
                    if (rx_q) begin
                        state_d = S_IDLE;
                        // An accept on this same cycle frees the buffer for the new byte.
                        if (!valid_q || rx_if.data_out_ready) begin
                            data_d  = shift_q;
                            valid_d = 1'b1;
                        end else begin
                            ovr_d = 1'b1;
                        end
                    end else begin
                        state_d = S_WAIT_HI;
                        ferr_d  = 1'b1;
                    end
                end
            end
            S_WAIT_HI: begin
                if (rx_q) begin
                    state_d = S_IDLE;
                    cnt_d   = '0;
                end
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q  <= 1'b1;
            rx_q    <= 1'b1;
            state_q <= S_IDLE;
            cnt_q   <= '0;
            idx_q   <= 3'd0;
            shift_q <= 8'h00;
            data_q  <= 8'h00;
            valid_q <= 1'b0;
            ferr_q  <= 1'b0;
            ovr_q   <= 1'b0;
        end else begin
            sync_q  <= serial_in;
            rx_q    <= sync_q;
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            shift_q <= shift_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            ferr_q  <= ferr_d;
            ovr_q   <= ovr_d;
        end
    end

    assign rx_if.data_out       = data_q;
    assign rx_if.data_out_valid = valid_q;
    assign rx_if.framing_error  = ferr_q;
    assign rx_if.overrun        = ovr_q;

endmodule

// File: tb/tb_uart_receiver.sv
// Self-checking bench for uart_receiver: frame-level reference model feeds
// expectation queues that an independent monitor drains.
module tb_uart_receiver;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic serial_in = 1'b1;

    uart_receiver_if u_if ();

    uart_receiver #(.CLOCK_FREQ(50_000_000), .BAUD_RATE(1_000_000)) dut (
        .clk       (clk),
        .rst       (rst),
        .serial_in (serial_in),
        .rx_if     (u_if)
    );

    always #10 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model: what each frame should produce at the byte level.
    logic [7:0] byte_q[$];
    int         ferr_pending = 0;
    int         ovr_pending  = 0;
    bit         auto_ready   = 0;
    bit         model_held   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic line(input logic b, input int n);
        serial_in = b;
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send_frame(input logic [7:0] b, input logic stop, input int per);
        if (!stop) ferr_pending++;
        else if (auto_ready) byte_q.push_back(b);
        else if (model_held) ovr_pending++;
        else begin
            byte_q.push_back(b);
            model_held = 1;
        end
        line(1'b0, per);
        for (int i = 0; i < 8; i++) line(b[i], per);
        line(stop, per);
    endtask

    task automatic wait_valid(input string name, input int bound);
        int n;
        n = 0;
        while (u_if.data_out_valid !== 1'b1 && n < bound) begin
            @(posedge clk);
            #1;
            n++;
        end
        checks++;
        if (u_if.data_out_valid !== 1'b1) begin
            errors++;
            $display("FAIL %s: valid not seen within %0d cycles", name, bound);
        end
    endtask

    task automatic accept_one();
        u_if.data_out_ready = 1'b1;
        @(posedge clk);
        #1;
        u_if.data_out_ready = 1'b0;
        model_held = 0;
        check("valid_clears_after_accept", u_if.data_out_valid, 1'b0);
    endtask

    // Monitor: drains expectations whenever the DUT presents a result.
    logic [7:0] prev_data;
    logic       prev_valid = 1'b0;
    logic       prev_acc   = 1'b0;

    always @(negedge clk) begin
        if (!rst) begin
            if (u_if.framing_error === 1'b1) begin
                checks++;
                if (ferr_pending == 0) begin
                    errors++;
                    $display("FAIL framing_error: got pulse expected none");
                end else ferr_pending--;
            end
            if (u_if.overrun === 1'b1) begin
                checks++;
                if (ovr_pending == 0) begin
                    errors++;
                    $display("FAIL overrun: got pulse expected none");
                end else ovr_pending--;
            end
            if (prev_valid && u_if.data_out_valid && !prev_acc) begin
                checks++;
                if (u_if.data_out !== prev_data) begin
                    errors++;
                    $display("FAIL data_stable: got %0h expected %0h", u_if.data_out, prev_data);
                end
            end
            if (u_if.data_out_valid === 1'b1 && u_if.data_out_ready === 1'b1) begin
                checks++;
                if (byte_q.size() == 0) begin
                    errors++;
                    $display("FAIL byte: got %0h expected no byte", u_if.data_out);
                end else begin
                    logic [7:0] e;
                    e = byte_q.pop_front();
                    if (u_if.data_out !== e) begin
                        errors++;
                        $display("FAIL byte: got %0h expected %0h", u_if.data_out, e);
                    end
                end
            end
        end
        prev_valid <= u_if.data_out_valid;
        prev_data  <= u_if.data_out;
        prev_acc   <= u_if.data_out_valid && u_if.data_out_ready;
    end

    initial begin
        int         lat;
        string      s;
        logic [7:0] ca;

        u_if.data_out_ready = 1'b0;

        // Reset and idle
        repeat (10) begin
            @(posedge clk);
            #1;
        end
        check("rst_data_out", u_if.data_out, 8'h00);
        check("rst_valid", u_if.data_out_valid, 1'b0);
        check("rst_framing_error", u_if.framing_error, 1'b0);
        check("rst_overrun", u_if.overrun, 1'b0);
        rst = 1'b0;
        line(1'b1, 1000);
        check("idle_valid", u_if.data_out_valid, 1'b0);

        // Single byte with latency measurement
        lat = -1;
        fork
            send_frame(8'hA5, 1'b1, 50);
            begin
                int cyc;
                cyc = 0;
                while (lat < 0 && cyc < 1000) begin
                    @(posedge clk);
                    @(negedge clk);
                    if (u_if.data_out_valid === 1'b1) lat = cyc;
                    cyc++;
                end
            end
        join
        checks++;
        if (lat < 477 || lat > 479) begin
            errors++;
            $display("FAIL latency: got %0d expected 478+-1", lat);
        end
        check("single_data", u_if.data_out, 8'hA5);
        line(1'b1, 20);
        accept_one();

        // Back-to-back string, ready held high
        auto_ready = 1;
        u_if.data_out_ready = 1'b1;
        s = "sw 30000008\r";
        for (int i = 0; i < s.len(); i++) send_frame(s[i], 1'b1, 50);
        line(1'b1, 100);
        check("b2b_all_received", byte_q.size(), 0);
        auto_ready = 0;
        u_if.data_out_ready = 1'b0;

        // Glitch then framing error
        line(1'b0, 10);
        line(1'b1, 200);
        check("glitch_no_valid", u_if.data_out_valid, 1'b0);
        send_frame(8'h3E, 1'b0, 50);
        line(1'b0, 40);
        line(1'b1, 60);
        check("framing_reported", ferr_pending, 0);
        check("framing_no_valid", u_if.data_out_valid, 1'b0);
        send_frame(8'h31, 1'b1, 50);
        wait_valid("after_framing", 100);
        check("after_framing_data", u_if.data_out, 8'h31);
        accept_one();
        line(1'b1, 20);

        // Overrun
        send_frame(8'h61, 1'b1, 50);
        send_frame(8'h62, 1'b1, 50);
        line(1'b1, 20);
        check("overrun_reported", ovr_pending, 0);
        check("overrun_keeps_old", u_if.data_out, 8'h61);
        accept_one();
        line(1'b1, 20);

        // Reset during bit 4 of 0xCA
        ca = 8'hCA;
        line(1'b0, 50);
        for (int i = 0; i < 4; i++) line(ca[i], 50);
        line(ca[4], 25);
        rst = 1'b1;
        line(1'b1, 5);
        rst = 1'b0;
        line(1'b1, 600);
        check("midreset_no_valid", u_if.data_out_valid, 1'b0);
        send_frame(8'h0D, 1'b1, 50);
        wait_valid("after_reset", 100);
        check("after_reset_data", u_if.data_out, 8'h0D);
        accept_one();
        line(1'b1, 20);

        // Random bytes, gaps and bit periods within tolerance
        auto_ready = 1;
        u_if.data_out_ready = 1'b1;
        for (int i = 0; i < 24; i++) begin
            send_frame(8'($urandom_range(0, 255)), 1'b1, int'($urandom_range(49, 51)));
            line(1'b1, int'($urandom_range(0, 20)));
        end
        line(1'b1, 100);
        check("random_all_received", byte_q.size(), 0);
        check("final_ferr_pending", ferr_pending, 0);
        check("final_ovr_pending", ovr_pending, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
